// File: rtl/hub75_rx.sv
`default_nettype none
// ============================================================================
// Module   : hub75_rx
// Purpose  : Receive-side HUB75 PHY and line decoder. It samples the raw HUB75
//            pads in the local clock domain. It turns every shifted column into
//            a column-indexed pixel write, reports latch commits with the line
//            length and overflow status, and measures the unblanked on-time.
// Ports    : clk, rst_n          - clock and async active-low reset
//            hub75_addr/data     - row address / colour data pads (async)
//            hub75_clk/le/blank  - shift clock / latch / blank pads (async)
//            wr_valid/col/data   - per-column pixel write stream
//            line_valid/addr/len/ovf - latch commit report
//            on_valid/on_time    - unblanked period length report
//            blank_out           - synchronized blank level
// Revision : 1.0 - initial release
// ============================================================================
module hub75_rx #(
  parameter int N_BANKS    = 2,
  parameter int N_ROWS     = 32,
  parameter int N_COLS     = 64,
  parameter int N_CHANS    = 3,
  parameter int OT_W       = 16,
  parameter int SDW        = N_BANKS * N_CHANS,
  parameter int LOG_N_ROWS = $clog2(N_ROWS),
  parameter int LOG_N_COLS = $clog2(N_COLS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LOG_N_ROWS-1:0] hub75_addr,
  input  logic [SDW-1:0]        hub75_data,
  input  logic                  hub75_clk,
  input  logic                  hub75_le,
  input  logic                  hub75_blank,
  output logic                  wr_valid,
  output logic [LOG_N_COLS-1:0] wr_col,
  output logic [SDW-1:0]        wr_data,
  output logic                  line_valid,
  output logic [LOG_N_ROWS-1:0] line_addr,
  output logic [LOG_N_COLS:0]   line_len,
  output logic                  line_ovf,
  output logic                  on_valid,
  output logic [OT_W-1:0]       on_time,
  output logic                  blank_out
);

  localparam logic [LOG_N_COLS:0] c_col_limit = (LOG_N_COLS+1)'(N_COLS);
  localparam logic [OT_W-1:0]     c_on_max    = {OT_W{1'b1}};

  // Synchronizer stages. The strobes carry a third stage (s3) for edge
  // detection. Data and address stop at s2, which keeps them aligned with the
  // synchronized strobe that qualifies them.
  logic                  r_clk_s1, r_clk_s2, r_clk_s3;
  logic                  r_le_s1, r_le_s2, r_le_s3;
  logic                  r_blank_s1, r_blank_s2, r_blank_s3;
  logic [SDW-1:0]        r_data_s1, r_data_s2;
  logic [LOG_N_ROWS-1:0] r_addr_s1, r_addr_s2;

  logic [LOG_N_COLS:0]   r_col_cnt;
  logic                  r_ovf;
  logic [OT_W-1:0]       r_on_cnt;

  logic                  w_clk_rise;
  logic                  w_le_rise;
  logic                  w_blank_rise;
  logic                  w_blank_fall;
  logic                  w_shift_ok;
  logic [LOG_N_COLS:0]   w_col_next;
  logic                  w_ovf_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1   <= 1'b0;
      r_clk_s2   <= 1'b0;
      r_clk_s3   <= 1'b0;
      r_le_s1    <= 1'b0;
      r_le_s2    <= 1'b0;
      r_le_s3    <= 1'b0;
      r_blank_s1 <= 1'b0;
      r_blank_s2 <= 1'b0;
      r_blank_s3 <= 1'b0;
      r_data_s1  <= '0;
      r_data_s2  <= '0;
      r_addr_s1  <= '0;
      r_addr_s2  <= '0;
    end else begin
      r_clk_s1   <= hub75_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_s3   <= r_clk_s2;
      r_le_s1    <= hub75_le;
      r_le_s2    <= r_le_s1;
      r_le_s3    <= r_le_s2;
      r_blank_s1 <= hub75_blank;
      r_blank_s2 <= r_blank_s1;
      r_blank_s3 <= r_blank_s2;
      r_data_s1  <= hub75_data;
      r_data_s2  <= r_data_s1;
      r_addr_s1  <= hub75_addr;
      r_addr_s2  <= r_addr_s1;
    end
  end

  assign w_clk_rise   =  r_clk_s2   & ~r_clk_s3;
  assign w_le_rise    =  r_le_s2    & ~r_le_s3;
  assign w_blank_rise =  r_blank_s2 & ~r_blank_s3;
  assign w_blank_fall = ~r_blank_s2 &  r_blank_s3;

  // The shift is resolved before the latch, so a shift landing in the same
  // cycle as a latch belongs to the line being committed.
  assign w_shift_ok = w_clk_rise && (r_col_cnt < c_col_limit);
  assign w_col_next = w_shift_ok ? r_col_cnt + (LOG_N_COLS+1)'(1) : r_col_cnt;
  assign w_ovf_next = r_ovf | (w_clk_rise & ~w_shift_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_valid   <= 1'b0;
      wr_col     <= '0;
      wr_data    <= '0;
      line_valid <= 1'b0;
      line_addr  <= '0;
      line_len   <= '0;
      line_ovf   <= 1'b0;
      r_col_cnt  <= '0;
      r_ovf      <= 1'b0;
    end else begin
      wr_valid   <= w_shift_ok;
      line_valid <= w_le_rise;
      if (w_shift_ok) begin
        wr_col  <= r_col_cnt[LOG_N_COLS-1:0];
        wr_data <= r_data_s2;
      end
      if (w_le_rise) begin
        line_addr <= r_addr_s2;
        line_len  <= w_col_next;
        line_ovf  <= w_ovf_next;
        r_col_cnt <= '0;
        r_ovf     <= 1'b0;
      end else begin
        r_col_cnt <= w_col_next;
        r_ovf     <= w_ovf_next;
      end
    end
  end

  // On-time counter. It counts every cycle in which the synchronized blank
  // is low. The falling-edge cycle is itself the first low cycle, so the
  // restart loads 1 rather than 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on_valid <= 1'b0;
      on_time  <= '0;
      r_on_cnt <= '0;
    end else begin
      on_valid <= w_blank_rise;
      if (w_blank_rise) begin
        on_time  <= r_on_cnt;
        r_on_cnt <= '0;
      end else if (w_blank_fall) begin
        r_on_cnt <= OT_W'(1);
      end else if (!r_blank_s2 && (r_on_cnt != c_on_max)) begin
        r_on_cnt <= r_on_cnt + OT_W'(1);
      end
    end
  end

  assign blank_out = r_blank_s2;

endmodule
`default_nettype wire

// File: tb/tb_hub75_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_hub75_rx
// Purpose  : Directed self-checking bench for hub75_rx. It drives the pads
//            with directed vectors and compares the results against values
//            worked out by hand.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hub75_rx;

  localparam int N_BANKS    = 2;
  localparam int N_ROWS     = 32;
  localparam int N_COLS     = 64;
  localparam int N_CHANS    = 3;
  localparam int OT_W       = 16;
  localparam int SDW        = N_BANKS * N_CHANS;
  localparam int LOG_N_ROWS = $clog2(N_ROWS);
  localparam int LOG_N_COLS = $clog2(N_COLS);

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [LOG_N_ROWS-1:0] hub75_addr = '0;
  logic [SDW-1:0]        hub75_data = '0;
  logic                  hub75_clk = 1'b0;
  logic                  hub75_le = 1'b0;
  logic                  hub75_blank = 1'b1;
  logic                  wr_valid;
  logic [LOG_N_COLS-1:0] wr_col;
  logic [SDW-1:0]        wr_data;
  logic                  line_valid;
  logic [LOG_N_ROWS-1:0] line_addr;
  logic [LOG_N_COLS:0]   line_len;
  logic                  line_ovf;
  logic                  on_valid;
  logic [OT_W-1:0]       on_time;
  logic                  blank_out;

  hub75_rx #(
    .N_BANKS (N_BANKS),
    .N_ROWS  (N_ROWS),
    .N_COLS  (N_COLS),
    .N_CHANS (N_CHANS),
    .OT_W    (OT_W)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hub75_addr (hub75_addr),
    .hub75_data (hub75_data),
    .hub75_clk  (hub75_clk),
    .hub75_le   (hub75_le),
    .hub75_blank(hub75_blank),
    .wr_valid   (wr_valid),
    .wr_col     (wr_col),
    .wr_data    (wr_data),
    .line_valid (line_valid),
    .line_addr  (line_addr),
    .line_len   (line_len),
    .line_ovf   (line_ovf),
    .on_valid   (on_valid),
    .on_time    (on_time),
    .blank_out  (blank_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Captured output events, sampled 1 ns after each rising edge.
  int wq_col[$];
  int wq_data[$];
  int lq_addr[$];
  int lq_len[$];
  int lq_ovf[$];
  int oq_time[$];

  always @(posedge clk) begin
    #1;
    if (wr_valid) begin
      wq_col.push_back(int'(wr_col));
      wq_data.push_back(int'(wr_data));
    end
    if (line_valid) begin
      lq_addr.push_back(int'(line_addr));
      lq_len.push_back(int'(line_len));
      lq_ovf.push_back(int'(line_ovf));
    end
    if (on_valid) oq_time.push_back(int'(on_time));
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    wq_col.delete();
    wq_data.delete();
    lq_addr.delete();
    lq_len.delete();
    lq_ovf.delete();
    oq_time.delete();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One column shift. Data is set one cycle ahead of the rising edge, the
  // shift clock is high for 2 cycles and low for 2 cycles, and the data is
  // held throughout.
  task automatic shift(input logic [SDW-1:0] d);
    @(negedge clk) hub75_data = d;
    @(negedge clk) hub75_clk = 1'b1;
    wait_cyc(2);
    hub75_clk = 1'b0;
    wait_cyc(2);
  endtask

  task automatic latch(input logic [LOG_N_ROWS-1:0] a);
    @(negedge clk) hub75_addr = a;
    @(negedge clk) hub75_le = 1'b1;
    wait_cyc(2);
    hub75_le = 1'b0;
    wait_cyc(2);
  endtask

  task automatic shift_latch(input logic [SDW-1:0] d, input logic [LOG_N_ROWS-1:0] a);
    @(negedge clk) begin hub75_data = d; hub75_addr = a; end
    @(negedge clk) begin hub75_clk = 1'b1; hub75_le = 1'b1; end
    wait_cyc(2);
    hub75_clk = 1'b0;
    hub75_le  = 1'b0;
    wait_cyc(2);
  endtask

  task automatic check_writes(input string tag, input int n);
    check_eq({tag, "_nwr"}, wq_col.size(), n);
    for (int i = 0; i < n && i < wq_col.size(); i++) begin
      check_eq({tag, "_col"},  wq_col[i],  i);
      check_eq({tag, "_data"}, wq_data[i], i % 64);
    end
  endtask

  task automatic check_line(input string tag, input int addr, input int len, input int ovf);
    check_eq({tag, "_nline"}, lq_len.size(), 1);
    if (lq_len.size() > 0) begin
      check_eq({tag, "_addr"}, lq_addr[0], addr);
      check_eq({tag, "_len"},  lq_len[0],  len);
      check_eq({tag, "_ovf"},  lq_ovf[0],  ovf);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_wr_valid"},   wr_valid,   0);
    check_eq({tag, "_wr_col"},     wr_col,     0);
    check_eq({tag, "_wr_data"},    wr_data,    0);
    check_eq({tag, "_line_valid"}, line_valid, 0);
    check_eq({tag, "_line_addr"},  line_addr,  0);
    check_eq({tag, "_line_len"},   line_len,   0);
    check_eq({tag, "_line_ovf"},   line_ovf,   0);
    check_eq({tag, "_on_valid"},   on_valid,   0);
    check_eq({tag, "_on_time"},    on_time,    0);
    check_eq({tag, "_blank_out"},  blank_out,  0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    // Reset state.
    wait_cyc(4);
    check_all_zero("rst");
    rst_n = 1'b1;
    wait_cyc(8);
    clear_q();

    // Full 64-column line, then latch on row 5.
    for (int i = 0; i < 64; i++) shift(SDW'(i));
    latch(5'd5);
    wait_cyc(6);
    check_writes("full", 64);
    check_line("full", 5, 64, 0);
    check_eq("full_hold_col", wr_col, 63);
    clear_q();

    // Overflowing line of 70 shifts, then a normal 10-shift line.
    for (int i = 0; i < 70; i++) shift(SDW'(i));
    latch(5'd7);
    wait_cyc(6);
    check_writes("ovf", 64);
    check_line("ovf", 7, 64, 1);
    clear_q();
    for (int i = 0; i < 10; i++) shift(SDW'(i));
    latch(5'd8);
    wait_cyc(6);
    check_writes("after_ovf", 10);
    check_line("after_ovf", 8, 10, 0);
    clear_q();

    // Shift and latch in the same cycle after 9 shifts.
    for (int i = 0; i < 9; i++) shift(SDW'(i));
    shift_latch(SDW'(9), 5'd3);
    wait_cyc(6);
    check_writes("simul", 10);
    check_line("simul", 3, 10, 0);
    clear_q();
    shift(SDW'(0));
    wait_cyc(6);
    check_writes("simul_next", 1);
    latch(5'd4);
    wait_cyc(6);
    check_line("simul_next", 4, 1, 0);
    clear_q();

    // Blank low for 37 cycles.
    @(negedge clk) hub75_blank = 1'b0;
    wait_cyc(10);
    check_eq("blank_out_low", blank_out, 0);
    wait_cyc(27);
    hub75_blank = 1'b1;
    wait_cyc(6);
    check_eq("blank_out_high", blank_out, 1);
    check_eq("on37_n", oq_time.size(), 1);
    if (oq_time.size() > 0) check_eq("on37_time", oq_time[0], 37);
    clear_q();

    // Blank low long enough to saturate the counter.
    @(negedge clk) hub75_blank = 1'b0;
    wait_cyc(70000);
    hub75_blank = 1'b1;
    wait_cyc(6);
    check_eq("onsat_n", oq_time.size(), 1);
    if (oq_time.size() > 0) check_eq("onsat_time", oq_time[0], 65535);
    check_eq("onsat_hold", on_time, 65535);
    clear_q();

    // Reset mid-line after 20 shifts.
    for (int i = 0; i < 20; i++) shift(SDW'(i));
    @(negedge clk) rst_n = 1'b0;
    wait_cyc(3);
    check_all_zero("midrst");
    rst_n = 1'b1;
    wait_cyc(8);
    clear_q();
    for (int i = 0; i < 3; i++) shift(SDW'(i));
    latch(5'd9);
    wait_cyc(6);
    check_writes("midrst", 3);
    check_line("midrst", 9, 3, 0);
    clear_q();

    // Single shift edge: exact pulse latency and width.
    @(negedge clk) hub75_data = SDW'(6'h2A);
    @(negedge clk) hub75_clk = 1'b1;
    @(posedge clk); #1;
    check_eq("lat_k0", wr_valid, 0);
    @(posedge clk); #1;
    check_eq("lat_k1", wr_valid, 0);
    @(posedge clk); #1;
    check_eq("lat_k2", wr_valid, 1);
    check_eq("lat_col", wr_col, 0);
    check_eq("lat_data", wr_data, 32'h2A);
    @(posedge clk); #1;
    check_eq("lat_k3", wr_valid, 0);
    @(negedge clk) hub75_clk = 1'b0;
    wait_cyc(4);
    latch(5'd1);
    wait_cyc(6);
    clear_q();

    // Latch without any shift.
    latch(5'd2);
    wait_cyc(6);
    check_line("empty", 2, 0, 0);
    check_eq("empty_nwr", wq_col.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
